// File: rtl/mem_wb_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_skid_reg
//  Purpose  : MEM->WB pipeline register with valid/ready handshake and a
//             2-entry skid buffer, freeze, flush, occupancy report and a
//             saturating stall counter. Upstream ready is registered apart
//             from the freeze term.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic [DEST_W-1:0] dest,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload layout, MSB first: {wb_en, mem_r_en, dest, alu_res, mem_data}
  localparam int PAY_W = 2 + DEST_W + 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Encoding is {head_valid, skid_valid}; (0,1) is never produced.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [PAY_W-1:0]   head_q, skid_q, in_pay;
  logic [CNT_W-1:0]   stall_q;
  logic               head_valid, skid_valid;
  logic               in_fire, out_fire;
  logic               load_head_in, load_head_skid, load_skid;
  logic               stall_inc;

  assign head_valid = state_q[1];
  assign skid_valid = state_q[0];
  assign in_pay     = {wb_en, mem_r_en, dest, alu_res, mem_data};

  // Freeze is the only combinational contributor to the handshake outputs.
  assign in_ready  = ~skid_valid & ~freeze;
  assign out_valid = head_valid & ~freeze;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign wb_en_out    = out_valid & head_q[PAY_W-1];
  assign mem_r_en_out = out_valid & head_q[PAY_W-2];
  assign dest_out     = head_q[2*DATA_W +: DEST_W];
  assign alu_res_out  = head_q[DATA_W +: DATA_W];
  assign mem_data_out = head_q[0 +: DATA_W];

  assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_q;

  // A stalled cycle is one where WB is offered an entry and refuses it.
  assign stall_inc = out_valid & ~out_ready & ~flush & (stall_q != CNT_MAX);

  // Next-state and payload-steering decisions for the two-entry buffer.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      // Under freeze both fire terms are low, so everything holds here.
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_head_in = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, payload and stall-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_head_in) begin
        head_q <= in_pay;
      end else if (load_head_skid) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pay;
      end
      if (stall_inc) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
